// File: rtl/pipemem_lsu_pkg.sv
// Shared pipeline definitions for the MEM-stage load/store unit.
package pipemem_lsu_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } lsu_state_t;

    localparam int TIMEOUT_DEFAULT = 15;
    localparam int WCNT_W          = 4;

endpackage

// File: rtl/pipemem_lsu_pipeemreg.sv
// EX/MEM pipeline register; loads the EXE-stage fields whenever the MEM stage is not stalled.
module pipeemreg (
    input  logic        clock,
    input  logic        resetn,
    input  logic        en,
    input  logic        ewreg,
    input  logic        em2reg,
    input  logic        ewmem,
    input  logic [4:0]  ern,
    input  logic [31:0] ealu,
    input  logic [31:0] eb,
    output logic        wreg_q,
    output logic        m2reg_q,
    output logic        wmem_q,
    output logic [4:0]  rn_q,
    output logic [31:0] alu_q,
    output logic [31:0] b_q
);

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            wreg_q  <= 1'b0;
            m2reg_q <= 1'b0;
            wmem_q  <= 1'b0;
            rn_q    <= 5'd0;
            alu_q   <= 32'd0;
            b_q     <= 32'd0;
        end else if (en) begin
            wreg_q  <= ewreg;
            m2reg_q <= em2reg;
            wmem_q  <= ewmem;
            rn_q    <= ern;
            alu_q   <= ealu;
            b_q     <= eb;
        end
    end

endmodule

// File: rtl/pipemem_lsu.sv
// MEM-stage load/store unit: EX/MEM register, memory handshake FSM with wait timeout,
// stall generation and MEM/WB-side outputs.
//   state | meaning
//   IDLE  | no memory access outstanding; EX/MEM register free-running
//   BUSY  | access for the op held in EX/MEM is on the bus, waiting for mem_ack
module pipemem_lsu
    import pipemem_lsu_pkg::*;
#(
    parameter int TIMEOUT = TIMEOUT_DEFAULT
) (
    input  logic        clock,
    input  logic        resetn,
    input  logic        ewreg,
    input  logic        em2reg,
    input  logic        ewmem,
    input  logic [4:0]  ern,
    input  logic [31:0] ealu,
    input  logic [31:0] eb,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata,
    output logic        mwreg,
    output logic        mm2reg,
    output logic [4:0]  mrn,
    output logic [31:0] malu,
    output logic [31:0] mmo,
    output logic        mstall,
    output logic        merr
);

    localparam logic [WCNT_W-1:0] TO_CNT = WCNT_W'(TIMEOUT);

    lsu_state_t        state, state_nxt;
    logic              wreg_q, m2reg_q, wmem_q;
    logic [4:0]        rn_q;
    logic [31:0]       alu_q, b_q, mmo_q;
    logic [WCNT_W-1:0] wcnt;
    logic              busy, acked, timeout, mem_op;

    assign busy   = (state == BUSY);
    assign mem_op = em2reg | ewmem;

    pipeemreg u_emreg (
        .clock   (clock),
        .resetn  (resetn),
        .en      (~mstall),
        .ewreg   (ewreg),
        .em2reg  (em2reg),
        .ewmem   (ewmem),
        .ern     (ern),
        .ealu    (ealu),
        .eb      (eb),
        .wreg_q  (wreg_q),
        .m2reg_q (m2reg_q),
        .wmem_q  (wmem_q),
        .rn_q    (rn_q),
        .alu_q   (alu_q),
        .b_q     (b_q)
    );

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) state <= IDLE;
        else         state <= state_nxt;
    end

    // A timed-out access completes like an ack, so the pipeline moves on instead of hanging.
    always_comb begin
        state_nxt = state;
        mstall    = 1'b0;
        acked     = 1'b0;
        timeout   = 1'b0;
        if (busy) begin
            if (mem_ack)              acked   = 1'b1;
            else if (wcnt == TO_CNT)  timeout = 1'b1;
            else                      mstall  = 1'b1;
        end
        if (!busy || acked || timeout) state_nxt = mem_op ? BUSY : IDLE;
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            wcnt  <= '0;
            mmo_q <= 32'd0;
            merr  <= 1'b0;
        end else begin
            if (mstall) wcnt <= wcnt + 1'b1;
            else        wcnt <= '0;
            if (acked && m2reg_q)        mmo_q <= mem_rdata;
            else if (timeout && m2reg_q) mmo_q <= 32'd0;
            if (timeout) merr <= 1'b1;
        end
    end

    assign mem_req   = busy;
    assign mem_we    = wmem_q;
    assign mem_addr  = alu_q;
    assign mem_wdata = b_q;

    assign mmo    = acked ? mem_rdata : ((timeout && m2reg_q) ? 32'd0 : mmo_q);
    assign mwreg  = wreg_q & ~mstall & ~(timeout & m2reg_q);
    assign mm2reg = m2reg_q;
    assign mrn    = rn_q;
    assign malu   = alu_q;

endmodule
